// File: rtl/sram_ctrl.sv
// sram_ctrl - single-word request front end driving a 64-bit-wide SRAM bus.
//
// The SRAM stores two adjacent 32-bit words per bus beat: mem[a] on DQ[31:0]
// and mem[a+1] on DQ[63:32]. A 32-bit write must therefore preserve the
// neighbouring word. With SRAM_CTRL_RMW_EN defined, each write reads the pair
// first and writes back {old upper, new word}. With the macro undefined,
// writes go straight to the bus and clear the neighbouring word.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = write, 0 = read
//   req_addr          byte address; bits [1:0] ignored, high bits range-checked
//   req_wdata         write data
//   resp_valid        one-cycle completion pulse
//   resp_err          request address was out of range (with resp_valid)
//   resp_rdata        read data (with resp_valid on reads, else 0)
//   SRAM_WE_N         registered active-low write enable
//   SRAM_ADDR         registered bus address {word[15:0], 1'b0}
//   SRAM_DQ           bidirectional data, driven only while SRAM_WE_N is low
//
// Configuration macro: SRAM_CTRL_RMW_EN (read-modify-write on writes).
module sram_ctrl #(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        SRAM_WE_N,
    output logic [16:0] SRAM_ADDR,
    inout  wire  [63:0] SRAM_DQ
);

    localparam int              AW    = $clog2(MEM_WORDS);
    localparam logic [AW-1:0]   TOP_W = AW'(MEM_WORDS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ERR  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;

    logic [2:0]    state;
    logic          we_q;
    logic [AW-1:0] w_q;
    logic [31:0]   wdata_q;
    logic [63:0]   dq_out;

    logic [AW-1:0] req_w;
    logic          req_oor;
    logic          unused_addr_bits;

    // Bus address for a word index: the SRAM addresses 16-bit halves of a
    // 32-bit word, hence the trailing zero.
    function automatic logic [16:0] bus_addr(input logic [AW-1:0] w);
        logic [15:0] w16;
        w16 = 16'(w);
        return {w16, 1'b0};
    endfunction

    // Write beat for read-modify-write: keep the neighbour's old contents,
    // except at the top word where there is no neighbour to preserve.
    function automatic logic [63:0] merge_word(input logic [31:0] upper,
                                               input logic [31:0] wdata,
                                               input logic        top);
        return {(top ? 32'h0 : upper), wdata};
    endfunction

    assign req_w            = req_addr[AW+1:2];
    assign req_oor          = (req_addr >> (AW + 2)) != 32'd0;
    assign unused_addr_bits = ^req_addr[1:0];
    assign req_ready        = (state == S_IDLE);

    // Output enable is the inverse of the registered write enable, so the
    // controller and the SRAM can never drive the bus in the same cycle.
    assign SRAM_DQ = SRAM_WE_N ? {64{1'bz}} : dq_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            SRAM_WE_N  <= 1'b1;
            SRAM_ADDR  <= 17'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_oor) begin
                            state <= S_ERR;
                        end else begin
                            SRAM_ADDR <= bus_addr(req_w);
`ifdef SRAM_CTRL_RMW_EN
                            state <= S_RD;
`else
                            if (req_we) begin
                                SRAM_WE_N <= 1'b0;
                                state     <= S_WR;
                            end else begin
                                state <= S_RD;
                            end
`endif
                        end
                    end
                end
                S_ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    state      <= S_IDLE;
                end
                // SRAM samples the address at the end of this cycle.
                S_RD: begin
                    state <= S_CAPT;
                end
                // SRAM drives the pair for w, w+1 during this cycle.
                S_CAPT: begin
                    if (we_q) begin
                        SRAM_WE_N <= 1'b0;
                        state     <= S_WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= SRAM_DQ[31:0];
                        state      <= S_IDLE;
                    end
                end
                S_WR: begin
                    SRAM_WE_N  <= 1'b1;
                    resp_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Request and write-beat data; only meaningful alongside the state above.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            we_q    <= req_we;
            w_q     <= req_w;
            wdata_q <= req_wdata;
`ifndef SRAM_CTRL_RMW_EN
            dq_out  <= {32'h0, req_wdata};
`endif
        end
        if (state == S_CAPT && we_q) begin
            dq_out <= merge_word(SRAM_DQ[63:32], wdata_q, w_q == TOP_W);
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl - directed plus randomized bench for sram_ctrl with a
// behavioural dual-word SRAM on the bus and a word-level reference memory.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_RMW_EN
    localparam bit RMW    = 1'b1;
    localparam int WR_LAT = 3;
`else
    localparam bit RMW    = 1'b0;
    localparam int WR_LAT = 1;
`endif
    localparam int WORDS = 512;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        SRAM_WE_N;
    logic [16:0] SRAM_ADDR;
    wire  [63:0] SRAM_DQ;

    int vectors;
    int miscompares;

    // behavioural SRAM
    logic [31:0] sram_mem [0:WORDS-1];
    logic [63:0] sram_rd_q;
    logic        clr;
    logic        pre_en;
    int          pre_idx;
    logic [31:0] pre_val;
    int          sa;

    // reference: what each word should hold
    logic [31:0] ref_mem [0:WORDS-1];
    logic [31:0] last_rdata;

    sram_ctrl #(.MEM_WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ    (SRAM_DQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb sa = int'(SRAM_ADDR[16:1]);

    assign SRAM_DQ = SRAM_WE_N ? sram_rd_q : {64{1'bz}};

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < WORDS; i++) sram_mem[i] <= 32'h0;
        end else if (pre_en) begin
            sram_mem[pre_idx] <= pre_val;
        end else if (!SRAM_WE_N) begin
            sram_mem[sa] <= SRAM_DQ[31:0];
            if (sa != WORDS - 1) sram_mem[sa + 1] <= SRAM_DQ[63:32];
        end
        if (SRAM_WE_N)
            sram_rd_q <= {((sa != WORDS - 1) ? sram_mem[sa + 1] : 32'hBAD0BAD0), sram_mem[sa]};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request, checked against the reference memory; updates the reference.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input string tag);
        int          w;
        logic        oor;
        int          k;
        int          welow;
        int          exp_lat;
        logic [31:0] exp_rd;
        w       = int'(addr[10:2]);
        oor     = (addr[31:11] != 21'd0);
        exp_lat = oor ? 1 : (we ? WR_LAT : 2);
        exp_rd  = (!we && !oor) ? ref_mem[w] : 32'h0;

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        k = 0;
        while (!req_ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".ready"}, 64'(req_ready), 64'(1));
        @(posedge clk); #1;   // acceptance edge
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk({tag, ".busy"}, 64'(req_ready), 64'(0));
        chk({tag, ".pulse"}, 64'(resp_valid), 64'(0));
        if (!oor) chk({tag, ".addr"}, 64'(SRAM_ADDR), 64'(w * 2));
        welow = SRAM_WE_N ? 0 : 1;
        k = 0;
        while (!resp_valid && k < 10) begin
            @(posedge clk); #1;
            k++;
            if (!SRAM_WE_N) begin
                welow++;
                if (w == WORDS - 1) chk({tag, ".topzero"}, 64'(SRAM_DQ[63:32]), 64'(0));
            end
        end
        chk({tag, ".lat"}, 64'(k), 64'(exp_lat));
        chk({tag, ".err"}, 64'(resp_err), 64'(oor));
        chk({tag, ".rdata"}, 64'(resp_rdata), 64'(exp_rd));
        chk({tag, ".welow"}, 64'(welow), 64'((we && !oor) ? 1 : 0));
        last_rdata = resp_rdata;
        if (we && !oor) begin
            ref_mem[w] = data;
            if (!RMW && w != WORDS - 1) ref_mem[w + 1] = 32'h0;
        end
    endtask

    initial begin
        int bad;
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        clr       = 1'b1;
        pre_en    = 1'b0;
        pre_idx   = 0;
        pre_val   = 32'h0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;

        // reset held three cycles, preloading the SRAM meanwhile
        @(posedge clk); #1;
        clr = 1'b0; pre_en = 1'b1; pre_idx = 4; pre_val = 32'hDEADBEEF;
        @(posedge clk); #1;
        pre_idx = 5; pre_val = 32'h12345678;
        @(posedge clk); #1;
        pre_en = 1'b0;
        ref_mem[4] = 32'hDEADBEEF;
        ref_mem[5] = 32'h12345678;
        chk("rst.we_n", 64'(SRAM_WE_N), 64'(1));
        chk("rst.ready", 64'(req_ready), 64'(1));
        chk("rst.valid", 64'(resp_valid), 64'(0));
        chk("rst.err", 64'(resp_err), 64'(0));
        chk("rst.rdata", 64'(resp_rdata), 64'(0));
        chk("rst.addr", 64'(SRAM_ADDR), 64'(0));
        chk("rst.dq", SRAM_DQ, sram_rd_q);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // read after preload
        txn(1'b0, 32'h10, 32'h0, "rd10");
        chk("rd10.value", 64'(last_rdata), 64'(32'hDEADBEEF));

        // write then read both words of the pair
        txn(1'b1, 32'h10, 32'hCAFEF00D, "wr10");
        txn(1'b0, 32'h10, 32'h0, "rd10b");
        chk("rd10b.value", 64'(last_rdata), 64'(32'hCAFEF00D));
        txn(1'b0, 32'h14, 32'h0, "rd14");
        chk("rd14.value", 64'(last_rdata), 64'(RMW ? 32'h12345678 : 32'h0));

        txn(1'b1, 32'h10, 32'h11111111, "wr11");
        chk("wr11.mem4", 64'(sram_mem[4]), 64'(32'h11111111));
        chk("wr11.mem5", 64'(sram_mem[5]), 64'(RMW ? 32'h12345678 : 32'h0));

        // top word and out of range
        txn(1'b1, 32'h7FC, 32'hA5A5A5A5, "wrtop");
        txn(1'b0, 32'h7FC, 32'h0, "rdtop");
        chk("rdtop.value", 64'(last_rdata), 64'(32'hA5A5A5A5));
        txn(1'b0, 32'h800, 32'h0, "rdoor");
        txn(1'b1, 32'hFFFF_0020, 32'h77777777, "wroor");

        // reset asserted while the write enable is low
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 6 && SRAM_WE_N; k++) begin
            @(posedge clk); #1;
        end
        chk("midwr.welow", 64'(SRAM_WE_N), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("midwr.we_n", 64'(SRAM_WE_N), 64'(1));
        chk("midwr.valid", 64'(resp_valid), 64'(0));
        chk("midwr.ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        chk("midwr.dq", SRAM_DQ, sram_rd_q);
        chk("midwr.valid2", 64'(resp_valid), 64'(0));
        chk("midwr.mem", 64'(sram_mem[8]), 64'(ref_mem[8]));
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 32'h20, 32'h0, "midwr.rd");

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic        we;
            logic [31:0] addr;
            int          sel;
            we  = 1'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                addr = $urandom;
                if (addr[31:11] == 21'd0) addr[20] = 1'b1;
            end else if (sel == 1) begin
                addr = {21'd0, 9'd511, 2'($urandom)};
            end else begin
                addr = {21'd0, 9'($urandom_range(0, 511)), 2'($urandom)};
            end
            txn(we, addr, $urandom, "rand");
        end

        bad = 0;
        for (int i = 0; i < WORDS; i++) if (sram_mem[i] !== ref_mem[i]) bad++;
        chk("memscan", 64'(bad), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
